serial_sub_8: RTL and testbench



---
 rtl/arith_pkg.sv | 12 +
 rtl/sub_1.sv | 13 +
 rtl/serial_sub_8.sv | 113 +++++++++++
 tb/tb_serial_sub_8.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state type and default datapath width.
package arith_pkg;

  localparam int ARITH_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

endpackage

// File: rtl/sub_1.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module sub_1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_8.sv
// Bit-serial subtractor: a - b computed LSB-first through one sub_1 cell and a
// registered borrow, one bit per clock, with a start/done handshake.
module serial_sub_8
  import arith_pkg::*;
#(
  parameter int N = ARITH_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         ovf
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  sub_state_t    r_state;
  sub_state_t    w_next;
  logic [N-1:0]  r_a_sr;
  logic [N-1:0]  r_b_sr;
  logic [N-2:0]  r_d_sr;
  logic          r_br;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_diff;
  logic          r_borrow;
  logic          r_ovf;
  logic          w_d;
  logic          w_bo;
  logic          w_last;
  logic [N-1:0]  w_d_next;

  sub_1 u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bo)
  );

  assign w_last   = (r_cnt == LAST);
  // Only N-1 collected bits are stored; the newest bit joins them on the way out.
  assign w_d_next = {w_d, r_d_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_d_sr   <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_br   <= 1'b0;
            r_cnt  <= '0;
          end
        end
        SHIFT: begin
          r_a_sr <= {1'b0, r_a_sr[N-1:1]};
          r_b_sr <= {1'b0, r_b_sr[N-1:1]};
          r_d_sr <= w_d_next[N-1:1];
          r_br   <= w_bo;
          // Counter holds at the last value so it never wraps mid-operation.
          if (w_last) begin
            r_diff   <= w_d_next;
            r_borrow <= w_bo;
            r_ovf    <= r_br ^ w_bo;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_sub_8.sv
// Self-checking bench for serial_sub_8: directed cases, back-to-back starts,
// mid-operation reset and a random sweep against an arithmetic reference.
module tb_serial_sub_8;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] expDiff;
  logic         expBorrow;
  logic         expOvf;

  serial_sub_8 #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed readings.
  task automatic refModel(input logic [N-1:0] x, input logic [N-1:0] y);
    int unsigned ux;
    int unsigned uy;
    int          sx;
    int          sy;
    int          s;
    ux = 32'(x);
    uy = 32'(y);
    sx = $signed(x);
    sy = $signed(y);
    s  = sx - sy;
    expDiff   = N'(ux - uy);
    expBorrow = (ux < uy);
    expOvf    = (s < -(1 << (N - 1))) || (s > (1 << (N - 1)) - 1);
  endtask

  task automatic checkResult(input string tag);
    checkOutput({tag, "_diff"}, 32'(diff), 32'(expDiff));
    checkOutput({tag, "_borrow"}, 32'(borrow), 32'(expBorrow));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
  endtask

  task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y,
                               input string tag);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 3 * N && !seen; i++) begin
      @(posedge clk);
      #1;
      if (i == N - 1) checkOutput({tag, "_hold"}, 32'(diff), 32'(expDiff));
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    checkOutput({tag, "_timeout"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, "_latency"}, lat, N);
      refModel(x, y);
      checkResult(tag);
      @(posedge clk);
      #1;
      checkOutput({tag, "_donepulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [N-1:0] opA[$];
    logic [N-1:0] opB[$];
    int           doneEdges[$];
    int           doneCount;

    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    expDiff   = '0;
    expBorrow = 1'b0;
    expOvf    = 1'b0;

    #12;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkResult("rst");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'd100, 8'd37, "tp1");
    checkOutput("tp1_const", 32'(diff), 32'd63);
    applyStimulus(8'd5, 8'd10, "tp2");
    checkOutput("tp2_const", 32'(diff), 32'hFB);
    checkOutput("tp2_bconst", 32'(borrow), 32'd1);
    applyStimulus(8'h80, 8'h01, "tp3");
    checkOutput("tp3_ovfconst", 32'(ovf), 32'd1);
    applyStimulus(8'h7F, 8'hFF, "tp4");
    checkOutput("tp4_const", 32'(diff), 32'h80);
    checkOutput("tp4_ovfconst", 32'(ovf), 32'd1);

    // Start held high with operands changing every cycle.
    @(negedge clk);
    start = 1'b1;
    a     = N'($urandom);
    b     = N'($urandom);
    opA.push_back(a);
    opB.push_back(b);
    for (int c = 0; c < 3 * N + 6; c++) begin
      @(posedge clk);
      #1;
      if (done && c >= N) begin
        doneEdges.push_back(c);
        refModel(opA[c-N], opB[c-N]);
        checkResult("cont");
      end
      a = N'($urandom);
      b = N'($urandom);
      opA.push_back(a);
      opB.push_back(b);
    end
    start = 1'b0;
    checkOutput("cont_count", doneEdges.size(), 3);
    for (int i = 1; i < doneEdges.size(); i++)
      checkOutput("cont_gap", doneEdges[i] - doneEdges[i-1], N + 2);

    // Reset in the middle of SHIFT after a nonzero result.
    applyStimulus(8'hC3, 8'h21, "prerst");
    @(negedge clk);
    a     = 8'h55;
    b     = 8'h77;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expDiff   = '0;
    expBorrow = 1'b0;
    expOvf    = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkResult("midrst");
    @(negedge clk);
    rst_n     = 1'b1;
    doneCount = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("midrst_nodone", doneCount, 0);
    applyStimulus(8'h00, 8'h00, "zero");

    applyStimulus(8'hFF, 8'hFF, "c_ffff");
    applyStimulus(8'h00, 8'hFF, "c_00ff");
    applyStimulus(8'hFF, 8'h00, "c_ff00");
    applyStimulus(8'h80, 8'h7F, "c_807f");
    applyStimulus(8'h7F, 8'h80, "c_7f80");

    for (int i = 0; i < 150; i++)
      applyStimulus(N'($urandom), N'($urandom), "rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
